// File: rtl/fb_pixel_unpacker.sv
// fb_pixel_unpacker: unpacks 32-bit frame-buffer words into 24-bit RGB pixels
// in ARGB8888, RGB565, GRAY8 or packed RGB888 format.
module fb_pixel_unpacker (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_type,
    input  logic [31:0] snk_data,
    input  logic        snk_valid,
    input  logic        snk_sop,
    input  logic        snk_eop,
    output logic        snk_ready,
    output logic [23:0] src_data,
    output logic        src_valid,
    output logic        src_sop,
    output logic        src_eop,
    input  logic        src_ready,
    output logic        frame_done,
    output logic        frame_err
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;
    logic        hold_valid, h_sop, h_eop;
    logic [31:0] h_word;
    logic [1:0]  fmt, phase, pix, pix_last;
    logic [15:0] carry, h565;
    logic [7:0]  gray;
    logic [23:0] pixel, rgb888;
    logic        last, xfer, retire, eop_xfer, acc, load, load_sop;
    logic        unused_bits;
    assign unused_bits = ^data_type[31:2];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = load_sop ? ACTIVE : eop_xfer ? IDLE : state;
    end
    always_comb begin
        snk_ready = !hold_valid || (hold_valid && src_ready && last);
        src_valid = hold_valid;
        src_sop   = hold_valid && h_sop && pix == 2'd0;
        src_eop   = hold_valid && h_eop && last;
        src_data  = hold_valid ? pixel : 24'h0;
    end
    // pix_last depends on the held word's phase for RGB888 (1,1,2 pixels per word)
    always_comb begin
        pix_last = fmt == 2'd0 ? 2'd0 : fmt == 2'd1 ? 2'd1 : fmt == 2'd2 ? 2'd3 :
                   (phase == 2'd2 ? 2'd1 : 2'd0);
        last     = pix == pix_last;
        xfer     = hold_valid && src_ready;
        retire   = xfer && last;
        eop_xfer = xfer && h_eop && last;
        acc      = snk_valid && snk_ready;
        load_sop = acc && snk_sop;
        load     = load_sop || (acc && state == ACTIVE && !eop_xfer);
    end
    always_comb begin
        h565   = pix[0] ? h_word[31:16] : h_word[15:0];
        gray   = h_word[{pix, 3'b000} +: 8];
        rgb888 = phase == 2'd0 ? h_word[23:0] :
                 phase == 2'd1 ? {h_word[15:0], carry[7:0]} :
                 pix[0] ? h_word[31:8] : {h_word[7:0], carry};
        pixel  = fmt == 2'd0 ? h_word[23:0] :
                 fmt == 2'd1 ? {h565[15:11], h565[15:13], h565[10:5], h565[10:9], h565[4:0], h565[4:2]} :
                 fmt == 2'd2 ? {gray, gray, gray} : rgb888;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            h_word     <= 32'h0;
            h_sop      <= 1'b0;
            h_eop      <= 1'b0;
            pix        <= 2'd0;
            fmt        <= 2'd0;
            phase      <= 2'd0;
            carry      <= 16'h0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (load) begin
                h_word <= snk_data;
                h_sop  <= snk_sop;
                h_eop  <= snk_eop;
            end
            hold_valid <= load || (hold_valid && !retire);
            pix        <= retire ? 2'd0 : xfer ? pix + 2'd1 : pix;
            if (load_sop) fmt <= data_type[1:0];
            // leftover RGB888 carry bytes never cross a frame boundary
            if (load_sop || (retire && h_eop)) begin
                phase <= 2'd0;
                carry <= 16'h0;
            end else if (retire && fmt == 2'd3) begin
                phase <= phase == 2'd2 ? 2'd0 : phase + 2'd1;
                carry <= phase == 2'd0 ? {8'h0, h_word[31:24]} : phase == 2'd1 ? h_word[31:16] : 16'h0;
            end
            frame_done <= eop_xfer;
            frame_err  <= load_sop && state == ACTIVE && !eop_xfer;
        end
    end
endmodule

// File: tb/tb_fb_pixel_unpacker.sv
// tb_fb_pixel_unpacker: scoreboard bench for fb_pixel_unpacker.
module tb_fb_pixel_unpacker;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_type = 32'h0;
    logic [31:0] snk_data = 32'h0;
    logic        snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0;
    logic        snk_ready;
    logic [23:0] src_data;
    logic        src_valid, src_sop, src_eop;
    logic        src_ready = 1'b1;
    logic        frame_done, frame_err;
    int tests = 0, fails = 0, cyc = 0, done_cnt = 0, err_cnt = 0;
    logic [25:0] exp_q[$];
    logic        tog = 1'b0, prev_stall = 1'b0;
    logic [23:0] prev_data = 24'h0;

    fb_pixel_unpacker dut (
        .clk(clk), .reset_n(reset_n), .data_type(data_type),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_ready(snk_ready), .src_data(src_data), .src_valid(src_valid),
        .src_sop(src_sop), .src_eop(src_eop), .src_ready(src_ready),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (tog) begin #1 src_ready = !src_ready; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (prev_stall && reset_n) chk("stable", {7'h0, src_valid, src_data}, {7'h0, 1'b1, prev_data});
        prev_stall = src_valid && !src_ready;
        prev_data  = src_data;
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (src_valid && src_ready) begin
            if (exp_q.size() == 0) chk("unexpected", {6'h0, src_sop, src_eop, src_data}, 32'hDEAD);
            else chk("pix", {6'h0, src_sop, src_eop, src_data}, {6'h0, exp_q.pop_front()});
        end
    end

    task automatic push(input logic s, input logic e, input logic [23:0] d);
        exp_q.push_back({s, e, d});
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e);
        logic got = 1'b0;
        snk_data = d; snk_sop = s; snk_eop = e; snk_valid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk) got = snk_ready;
            @(posedge clk); #1;
        end
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        if (!got) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int t0;
        #12;
        chk("rst_valid", {31'h0, src_valid}, 0);
        chk("rst_data", {8'h0, src_data}, 0);
        chk("rst_flags", {29'h0, src_sop, src_eop, frame_done}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, snk_ready}, 1);
        @(posedge clk); #1;

        // ARGB8888 at full rate
        data_type = 32'd0;
        push(1, 0, 24'h112233); push(0, 0, 24'h445566); push(0, 0, 24'h778899); push(0, 1, 24'hAABBCC);
        t0 = cyc;
        send(32'hFF112233, 1, 0); send(32'hFF445566, 0, 0);
        send(32'hFF778899, 0, 0); send(32'hFFAABBCC, 0, 1);
        chk("argb_rate", cyc - t0, 4);
        drain();
        chk("argb_done", done_cnt, 1);

        // RGB565 two pixels per word
        data_type = 32'hFFFF_FFF1;
        push(1, 0, 24'h00FF00); push(0, 1, 24'hFF0000);
        send(32'hF800_07E0, 1, 1);
        @(negedge clk);
        chk("565_ready_low", {31'h0, snk_ready}, 0);
        drain();
        chk("565_done", done_cnt, 2);

        // GRAY8 under toggling backpressure
        data_type = 32'd2;
        tog = 1'b1;
        push(1, 0, 24'h101010); push(0, 0, 24'h202020); push(0, 0, 24'h404040); push(0, 1, 24'h808080);
        send(32'h80402010, 1, 1);
        drain();
        tog = 1'b0; src_ready = 1'b1;
        chk("gray_done", done_cnt, 3);

        // RGB888 full cycle, short frame, then full cycle again from phase 0
        data_type = 32'd3;
        push(1, 0, 24'h332211); push(0, 0, 24'h665544); push(0, 0, 24'h998877); push(0, 1, 24'hCCBBAA);
        send(32'h44332211, 1, 0); send(32'h88776655, 0, 0); send(32'hCCBBAA99, 0, 1);
        drain();
        push(1, 0, 24'h332211); push(0, 1, 24'h665544);
        send(32'h44332211, 1, 0); send(32'h88776655, 0, 1);
        drain();
        push(1, 0, 24'h332211); push(0, 0, 24'h665544); push(0, 0, 24'h998877); push(0, 1, 24'hCCBBAA);
        send(32'h44332211, 1, 0); send(32'h88776655, 0, 0); send(32'hCCBBAA99, 0, 1);
        drain();
        chk("888_done", done_cnt, 6);

        // data_type rewritten mid-frame only affects the next frame
        data_type = 32'd0;
        push(1, 0, 24'h112233); push(0, 1, 24'h445566);
        send(32'hFF112233, 1, 0);
        data_type = 32'd2;
        send(32'h00445566, 0, 1);
        drain();
        push(1, 0, 24'h101010); push(0, 0, 24'h202020); push(0, 0, 24'h404040); push(0, 1, 24'h808080);
        send(32'h80402010, 1, 1);
        drain();
        chk("dt_done", done_cnt, 8);

        // SOP arriving mid-frame abandons the old frame
        data_type = 32'd0;
        push(1, 0, 24'h000001); push(0, 0, 24'h000002); push(1, 0, 24'h000003); push(0, 1, 24'h000004);
        send(32'h01000001, 1, 0); send(32'h01000002, 0, 0);
        send(32'h01000003, 1, 0); send(32'h01000004, 0, 1);
        drain();
        chk("mid_err", err_cnt, 1);
        chk("mid_done", done_cnt, 9);

        // asynchronous reset mid-frame, then non-SOP words are discarded
        src_ready = 1'b0;
        send(32'h00ABCDEF, 1, 0);
        @(negedge clk);
        chk("pre_rst_valid", {31'h0, src_valid}, 1);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_valid", {31'h0, src_valid}, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        src_ready = 1'b1;
        send(32'h00123456, 0, 1);
        repeat (5) @(negedge clk);
        chk("discard_valid", {31'h0, src_valid}, 0);
        chk("discard_done", done_cnt, 9);
        chk("final_q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
